// File: rtl/beam_ctrl_pkg.sv
// Shared types and constants for the four-channel beam combiner control slice.
package beam_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } state_e;

    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned NUM_W    = 2 * NUM_CH;
    localparam int unsigned WR_SEL_W = 3;

    // wr_sel = {ch[1:0], imag}
    localparam int unsigned SEL_IM_BIT = 0;
    localparam int unsigned SEL_CH_LSB = 1;
    localparam int unsigned SEL_CH_MSB = 2;

    localparam logic [WR_SEL_W-1:0] CH00_RE = 3'd0;
    localparam logic [WR_SEL_W-1:0] CH00_IM = 3'd1;
    localparam logic [WR_SEL_W-1:0] CH01_RE = 3'd2;
    localparam logic [WR_SEL_W-1:0] CH01_IM = 3'd3;
    localparam logic [WR_SEL_W-1:0] CH20_RE = 3'd4;
    localparam logic [WR_SEL_W-1:0] CH20_IM = 3'd5;
    localparam logic [WR_SEL_W-1:0] CH21_RE = 3'd6;
    localparam logic [WR_SEL_W-1:0] CH21_IM = 3'd7;

    function automatic logic [WR_SEL_W-1:0] weight_sel(input logic [1:0] ch, input logic imag);
        logic [WR_SEL_W-1:0] sel;
        sel = '0;
        sel[SEL_CH_MSB:SEL_CH_LSB] = ch;
        sel[SEL_IM_BIT] = imag;
        return sel;
    endfunction

endpackage

// File: rtl/beam_weight_bank.sv
// Double-buffered complex beam weights: shadow write port, active set, deferred commit.
module beam_weight_bank
    import beam_ctrl_pkg::*;
#(
    parameter int unsigned WEIGHT_WIDTH = 8
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic                          wr_en,
    input  logic [WR_SEL_W-1:0]           wr_sel,
    input  logic [WEIGHT_WIDTH-1:0]       wr_data,
    input  logic                          commit,
    input  logic                          boundary,
    input  logic                          idle,
    output logic [NUM_W*WEIGHT_WIDTH-1:0] w_active,
    output logic                          commit_pending
);

    logic [NUM_W-1:0][WEIGHT_WIDTH-1:0] shadow_q, shadow_d;
    logic [NUM_W-1:0][WEIGHT_WIDTH-1:0] active_q, active_d;
    logic                               pending_q, pending_d;
    logic                               swap;

    always_comb begin
        // Swap copies the pre-write shadow, so a same-cycle wr_en lands in shadow only.
        swap     = (boundary && pending_q) || (idle && (pending_q || commit));
        shadow_d = shadow_q;
        if (wr_en) begin
            shadow_d[wr_sel] = wr_data;
        end
        active_d = swap ? shadow_q : active_q;

        // A commit on a boundary arrives too late for that swap and waits for the next one.
        if (idle) begin
            pending_d = 1'b0;
        end else if (commit) begin
            pending_d = 1'b1;
        end else if (swap) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    assign w_active       = active_q;
    assign commit_pending = pending_q;

endmodule

// File: rtl/beam_combine_ctrl.sv
// Four-channel beam combiner sequencer: lockstep channel alignment, frame tracking,
// tlast-misalignment recovery and boundary-synchronous weight swap.
module beam_combine_ctrl
    import beam_ctrl_pkg::*;
#(
    parameter int unsigned WEIGHT_WIDTH = 8,
    parameter int unsigned FRAME_LEN    = 256
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           enable,
    input  logic [NUM_CH-1:0]              s_tvalid,
    input  logic [NUM_CH-1:0]              s_tlast,
    output logic [NUM_CH-1:0]              s_tready,
    output logic                           fire,
    output logic                           m_tvalid,
    output logic                           m_tlast,
    input  logic                           m_tready,
    input  logic                           wr_en,
    input  logic [WR_SEL_W-1:0]            wr_sel,
    input  logic [WEIGHT_WIDTH-1:0]        wr_data,
    input  logic                           commit,
    output logic [NUM_CH*2*WEIGHT_WIDTH-1:0] w_active,
    output logic                           commit_pending,
    output logic [15:0]                    frame_cnt,
    output logic                           err_misalign,
    input  logic                           err_clear,
    output logic [1:0]                     state
);

    localparam logic [15:0] LAST_BEAT = 16'(FRAME_LEN - 1);

    state_e              state_q, state_d;
    logic [15:0]         beat_cnt_q, beat_cnt_d;
    logic [15:0]         frame_cnt_q, frame_cnt_d;
    logic [NUM_CH-1:0]   done_q, done_d, done_set;
    logic                m_tvalid_q, m_tvalid_d;
    logic                m_tlast_q, m_tlast_d;
    logic                err_q, err_d;
    logic                exp_last, boundary, misaligned, flush_done;

    // A fire ends the frame when the counter says so or when any channel claims it does.
    assign exp_last   = (beat_cnt_q == LAST_BEAT);
    assign boundary   = fire && (exp_last || (|s_tlast));
    assign misaligned = fire && (s_tlast != {NUM_CH{exp_last}});
    assign done_set   = done_q | (s_tvalid & s_tready & s_tlast);
    assign flush_done = &done_set;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StRun;
            end
            StRun: begin
                if (boundary) begin
                    if (misaligned && !(&s_tlast)) state_d = StFlush;
                    else if (!enable)              state_d = StIdle;
                end
            end
            StFlush: begin
                if (flush_done) state_d = enable ? StRun : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // No s_tlast term here: ready never depends on tlast.
    always_comb begin
        fire     = 1'b0;
        s_tready = '0;
        unique case (state_q)
            StRun: begin
                fire     = (&s_tvalid) && (!m_tvalid_q || m_tready);
                s_tready = {NUM_CH{fire}};
            end
            StFlush: s_tready = ~done_q;
            default: ;
        endcase
    end

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        frame_cnt_d = frame_cnt_q;
        done_d      = done_q;
        m_tvalid_d  = m_tvalid_q;
        m_tlast_d   = m_tlast_q;

        if (state_q == StIdle) beat_cnt_d = '0;

        if (fire) begin
            if (boundary) begin
                beat_cnt_d  = '0;
                frame_cnt_d = frame_cnt_q + 16'd1;
            end else begin
                beat_cnt_d  = beat_cnt_q + 16'd1;
            end
        end

        if (state_q == StFlush) begin
            done_d = flush_done ? '0 : done_set;
        end else if (misaligned && !(&s_tlast)) begin
            done_d = s_tlast;
        end

        if (fire) begin
            m_tvalid_d = 1'b1;
            m_tlast_d  = boundary;
        end else if (m_tready) begin
            m_tvalid_d = 1'b0;
            m_tlast_d  = 1'b0;
        end

        if (misaligned)     err_d = 1'b1;
        else if (err_clear) err_d = 1'b0;
        else                err_d = err_q;
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            beat_cnt_q  <= '0;
            frame_cnt_q <= '0;
            done_q      <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            done_q      <= done_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            err_q       <= err_d;
        end
    end

    beam_weight_bank #(
        .WEIGHT_WIDTH (WEIGHT_WIDTH)
    ) u_weight_bank (
        .clock          (clock),
        .resetn         (resetn),
        .wr_en          (wr_en),
        .wr_sel         (wr_sel),
        .wr_data        (wr_data),
        .commit         (commit),
        .boundary       (boundary),
        .idle           (state_q == StIdle),
        .w_active       (w_active),
        .commit_pending (commit_pending)
    );

    assign m_tvalid     = m_tvalid_q;
    assign m_tlast      = m_tlast_q;
    assign frame_cnt    = frame_cnt_q;
    assign err_misalign = err_q;
    assign state        = state_q;

endmodule

// File: tb/tb_beam_combine_ctrl.sv
// Directed self-checking bench for beam_combine_ctrl with FRAME_LEN=4.
module tb_beam_combine_ctrl;
    import beam_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        resetn, enable, m_tready, wr_en, commit, err_clear;
    logic [3:0]  s_tvalid, s_tlast, s_tready;
    logic        fire, m_tvalid, m_tlast, commit_pending, err_misalign;
    logic [2:0]  wr_sel;
    logic [7:0]  wr_data;
    logic [63:0] w_active;
    logic [15:0] frame_cnt;
    logic [1:0]  state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    beam_combine_ctrl #(
        .WEIGHT_WIDTH (8),
        .FRAME_LEN    (4)
    ) dut (
        .clock          (clock),
        .resetn         (resetn),
        .enable         (enable),
        .s_tvalid       (s_tvalid),
        .s_tlast        (s_tlast),
        .s_tready       (s_tready),
        .fire           (fire),
        .m_tvalid       (m_tvalid),
        .m_tlast        (m_tlast),
        .m_tready       (m_tready),
        .wr_en          (wr_en),
        .wr_sel         (wr_sel),
        .wr_data        (wr_data),
        .commit         (commit),
        .w_active       (w_active),
        .commit_pending (commit_pending),
        .frame_cnt      (frame_cnt),
        .err_misalign   (err_misalign),
        .err_clear      (err_clear),
        .state          (state)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a full-width beat, confirm it fires, and clock it in.
    task automatic beat(input logic [3:0] last);
        s_tvalid = 4'hF;
        s_tlast  = last;
        #1;
        chk("fire", {63'd0, fire}, 64'd1);
        tick();
        s_tvalid = 4'h0;
        s_tlast  = 4'h0;
    endtask

    initial begin
        resetn = 0; enable = 0; m_tready = 1; wr_en = 0; commit = 0; err_clear = 0;
        s_tvalid = 0; s_tlast = 0; wr_sel = 0; wr_data = 0;
        tick(); tick();
        resetn = 1;
        #1;
        chk("rst_state", {62'd0, state}, 64'd0);
        chk("rst_mvalid", {63'd0, m_tvalid}, 64'd0);
        chk("rst_frames", {48'd0, frame_cnt}, 64'd0);
        chk("rst_weights", w_active, 64'd0);
        chk("rst_ready", {60'd0, s_tready}, 64'd0);

        // Nominal frame
        enable = 1;
        tick();
        chk("run_state", {62'd0, state}, 64'd1);
        beat(4'h0);
        chk("nom_mvalid", {63'd0, m_tvalid}, 64'd1);
        chk("nom_mlast0", {63'd0, m_tlast}, 64'd0);
        beat(4'h0);
        beat(4'h0);
        beat(4'hF);
        chk("nom_mlast3", {63'd0, m_tlast}, 64'd1);
        chk("nom_frames", {48'd0, frame_cnt}, 64'd1);
        tick();
        chk("nom_drain", {63'd0, m_tvalid}, 64'd0);

        // Channel skew: ch2 late by three cycles
        for (int i = 0; i < 3; i++) begin
            s_tvalid = 4'b1011;
            #1;
            chk("skew_fire", {63'd0, fire}, 64'd0);
            chk("skew_ready", {60'd0, s_tready}, 64'd0);
            tick();
        end
        beat(4'h0); beat(4'h0); beat(4'h0); beat(4'hF);
        chk("skew_frames", {48'd0, frame_cnt}, 64'd2);

        // Backpressure while the frame-last beat is held
        beat(4'h0); beat(4'h0); beat(4'h0); beat(4'hF);
        m_tready = 0;
        for (int i = 0; i < 5; i++) begin
            s_tvalid = 4'hF;
            #1;
            chk("bp_fire", {63'd0, fire}, 64'd0);
            chk("bp_hold", {62'd0, m_tvalid, m_tlast}, 64'd3);
            tick();
        end
        m_tready = 1;
        beat(4'h0);
        chk("bp_next", {62'd0, m_tvalid, m_tlast}, 64'd2);
        beat(4'h0); beat(4'h0); beat(4'hF);
        chk("bp_frames", {48'd0, frame_cnt}, 64'd4);
        chk("bp_noerr", {63'd0, err_misalign}, 64'd0);

        // Misalignment: ch1 ends early on beat 1; set beats a concurrent clear
        beat(4'h0);
        err_clear = 1;
        beat(4'b0010);
        err_clear = 0;
        chk("mis_err", {63'd0, err_misalign}, 64'd1);
        chk("mis_mlast", {63'd0, m_tlast}, 64'd1);
        chk("mis_state", {62'd0, state}, 64'd2);
        chk("mis_frames", {48'd0, frame_cnt}, 64'd5);
        chk("mis_ready0", {60'd0, s_tready}, 64'hD);
        s_tvalid = 4'b0001; s_tlast = 4'b0001;
        tick();
        s_tvalid = 4'b1000; s_tlast = 4'b0000;
        #1;
        chk("mis_ready1", {60'd0, s_tready}, 64'hC);
        tick();
        s_tvalid = 4'b1100; s_tlast = 4'b1100;
        #1;
        chk("mis_ready2", {60'd0, s_tready}, 64'hC);
        chk("mis_hold", {62'd0, state}, 64'd2);
        tick();
        s_tvalid = 0; s_tlast = 0;
        #1;
        chk("mis_resume", {62'd0, state}, 64'd1);
        chk("mis_ready3", {60'd0, s_tready}, 64'd0);
        err_clear = 1;
        tick();
        err_clear = 0;
        chk("err_clear", {63'd0, err_misalign}, 64'd0);

        // Weight commit at beat 2, applied after beat 3
        beat(4'h0); beat(4'h0);
        wr_en = 1; wr_sel = CH00_RE; wr_data = 8'h20; commit = 1;
        beat(4'h0);
        wr_en = 0; commit = 0;
        chk("wc_pending", {63'd0, commit_pending}, 64'd1);
        chk("wc_old", w_active, 64'd0);
        beat(4'hF);
        chk("wc_new", w_active, 64'h20);
        chk("wc_cleared", {63'd0, commit_pending}, 64'd0);

        // Commit coincident with last fire waits a frame; write in swap cycle stays shadow
        wr_en = 1; wr_sel = CH21_IM; wr_data = 8'h5A;
        beat(4'h0);
        wr_en = 0;
        beat(4'h0); beat(4'h0);
        commit = 1;
        beat(4'hF);
        commit = 0;
        chk("co_pending", {63'd0, commit_pending}, 64'd1);
        chk("co_old", w_active, 64'h20);
        beat(4'h0); beat(4'h0); beat(4'h0);
        wr_en = 1; wr_sel = CH21_IM; wr_data = 8'h33;
        beat(4'hF);
        wr_en = 0;
        chk("co_new", w_active, 64'h5A00_0000_0000_0020);
        chk("co_frames", {48'd0, frame_cnt}, 64'd8);

        // Stop at the frame boundary after deassert at beat 1
        beat(4'h0);
        enable = 0;
        beat(4'h0);
        chk("stop_run", {62'd0, state}, 64'd1);
        beat(4'h0); beat(4'hF);
        chk("stop_idle", {62'd0, state}, 64'd0);
        chk("stop_frames", {48'd0, frame_cnt}, 64'd9);
        s_tvalid = 4'hF;
        #1;
        chk("idle_fire", {59'd0, fire, s_tready}, 64'd0);
        s_tvalid = 0;
        commit = 1;
        tick();
        commit = 0;
        chk("idle_commit", w_active, 64'h3300_0000_0000_0020);

        // Reset mid-frame, then restart from beat 0
        enable = 1;
        tick();
        beat(4'h0); beat(4'h0);
        resetn = 0;
        tick();
        resetn = 1;
        chk("mrst_all", {w_active[15:0], frame_cnt, 28'd0, state, m_tvalid, m_tlast}, 64'd0);
        tick();
        chk("mrst_run", {62'd0, state}, 64'd1);
        beat(4'h0); beat(4'h0); beat(4'h0); beat(4'hF);
        chk("mrst_frame", {47'd0, err_misalign, frame_cnt}, 64'd1);
        chk("mrst_mlast", {63'd0, m_tlast}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
